// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and the idle instruction word.
// No logic; imported by instruction_fetch.
// No handshakes of its own.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads the word at pcAddress from memory and hands it to decode, strobing count on accept.
// Latency: REQ entry to instructionValid = 1 (grant) + L (memory) + 1 cycles; count is combinational.
// Backpressure: a word is held until decode is ready; no new request is issued while one is held.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcAddress,
    input  logic                  redirect,
    output logic                  count,
    output logic                  memReadReq,
    output logic [ADDR_WIDTH-1:0] memReadAddr,
    input  logic                  memReadGnt,
    input  logic                  memReadValid,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instructionPC,
    output logic                  instructionValid,
    input  logic                  instructionReady,
    output logic                  fetchFault
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         discard;
    logic         misaligned;

    assign misaligned = |pcAddress[1:0];

    always_comb begin
        state_nxt = state;
        count     = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // memReadReq low means this is the entry cycle: pcAddress is sampled now
                if (!memReadReq) begin
                    if (!redirect && misaligned)
                        state_nxt = FAULT;
                end else if (memReadGnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (memReadValid)
                    state_nxt = (discard || redirect) ? REQ : HOLD;
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = REQ;
                end else if (instructionReady) begin
                    state_nxt = REQ;
                    count     = 1'b1;
                end
            end
            FAULT: begin
                if (redirect)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            discard          <= 1'b0;
            memReadReq       <= 1'b0;
            memReadAddr      <= '0;
            instruction      <= DATA_WIDTH'(NOP_INSTR);
            instructionPC    <= '0;
            instructionValid <= 1'b0;
            fetchFault       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                REQ: begin
                    if (!memReadReq) begin
                        // A redirect here means pcAddress is stale; wait a cycle for the new PC
                        if (!redirect) begin
                            if (misaligned) begin
                                fetchFault <= 1'b1;
                            end else begin
                                memReadReq  <= 1'b1;
                                memReadAddr <= pcAddress;
                            end
                        end
                    end else begin
                        // Request is never withdrawn; its response is dropped instead
                        if (redirect)
                            discard <= 1'b1;
                        if (memReadGnt)
                            memReadReq <= 1'b0;
                    end
                end
                WAIT: begin
                    if (memReadValid) begin
                        discard <= 1'b0;
                        if (!discard && !redirect) begin
                            instruction      <= memReadData;
                            instructionPC    <= memReadAddr;
                            instructionValid <= 1'b1;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect || instructionReady)
                        instructionValid <= 1'b0;
                end
                FAULT: begin
                    if (redirect)
                        fetchFault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and memory models drive the DUT; every cycle the outputs are checked
// against the architectural PC, plus directed scenarios with literal expectations.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pcAddress;
    logic        redirect;
    logic        count;
    logic        memReadReq;
    logic [31:0] memReadAddr;
    logic        memReadGnt;
    logic        memReadValid;
    logic [31:0] memReadData;
    logic [31:0] instruction;
    logic [31:0] instructionPC;
    logic        instructionValid;
    logic        instructionReady;
    logic        fetchFault;

    instruction_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .pcAddress(pcAddress),
        .redirect(redirect),
        .count(count),
        .memReadReq(memReadReq),
        .memReadAddr(memReadAddr),
        .memReadGnt(memReadGnt),
        .memReadValid(memReadValid),
        .memReadData(memReadData),
        .instruction(instruction),
        .instructionPC(instructionPC),
        .instructionValid(instructionValid),
        .instructionReady(instructionReady),
        .fetchFault(fetchFault)
    );

    int          passed = 0;
    int          total  = 0;
    logic [31:0] pc_model;
    logic [31:0] newpc;
    int          pulses = 0;
    int          gnt_delay = 0;
    int          lat = 1;
    int          req_cycles = 0;
    bit          chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return (a == 32'h00400000) ? 32'h20080005 : (a ^ 32'h5A5A0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int n, output bit ok);
        n = 0;
        while (!instructionValid && n < max) begin
            tick();
            n++;
        end
        ok = instructionValid;
    endtask

    task automatic wait_req(input int max, output bit ok);
        int n = 0;
        while (!memReadReq && n < max) begin
            tick();
            n++;
        end
        ok = memReadReq;
    endtask

    task automatic wait_req_drop(input int max, output bit ok);
        int n = 0;
        while (memReadReq && n < max) begin
            tick();
            n++;
        end
        ok = !memReadReq;
    endtask

    // Program-order PC as the PC block would hold it
    initial begin
        logic        c, r;
        logic [31:0] np;
        forever begin
            @(posedge clk);
            c  = count;
            r  = redirect;
            np = newpc;
            #1;
            if (rst) begin
                if (r) begin
                    pc_model = np;
                end else if (c) begin
                    pc_model = pc_model + 32'd4;
                    pulses++;
                end
            end
            pcAddress = pc_model;
        end
    end

    // Memory: grant after gnt_delay waiting cycles, data lat cycles after grant
    initial begin
        bit          pending = 0;
        int          wcnt = 0;
        int          lcnt = 0;
        logic [31:0] paddr = '0;
        forever begin
            @(negedge clk);
            memReadGnt   = 1'b0;
            memReadValid = 1'b0;
            if (!rst) begin
                pending = 0;
                wcnt    = 0;
            end else if (pending) begin
                if (lcnt == 0) begin
                    memReadValid = 1'b1;
                    memReadData  = memfun(paddr);
                    pending      = 0;
                end else begin
                    lcnt--;
                end
            end else if (memReadReq) begin
                req_cycles++;
                if (wcnt < gnt_delay) begin
                    wcnt++;
                end else begin
                    memReadGnt = 1'b1;
                    paddr      = memReadAddr;
                    pending    = 1;
                    lcnt       = lat - 1;
                    wcnt       = 0;
                end
            end
        end
    end

    // Per-cycle compare against the PC/memory model
    initial begin
        logic        p_req = 0;
        logic        p_gnt = 0;
        logic [31:0] p_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en && rst) begin
                chk("count_rule", 32'(count), 32'(instructionValid && instructionReady && !redirect));
                if (instructionValid) begin
                    chk("instr_pc_model", instructionPC, pc_model);
                    chk("instr_word_model", instruction, memfun(pc_model));
                end
                if (fetchFault)
                    chk("fault_no_req", 32'(memReadReq), 32'd0);
                if (p_req && !p_gnt) begin
                    chk("req_held", 32'(memReadReq), 32'd1);
                    chk("req_addr_stable", memReadAddr, p_addr);
                end
                p_req  = memReadReq;
                p_gnt  = memReadGnt;
                p_addr = memReadAddr;
            end else begin
                p_req = 0;
                p_gnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit ok;
        bit saw, found, req_seen;
        int p0, r0;

        rst = 1'b0;
        redirect = 1'b0;
        instructionReady = 1'b0;
        newpc = '0;
        pc_model = 32'h00400000;
        pcAddress = pc_model;
        memReadGnt = 1'b0;
        memReadValid = 1'b0;
        memReadData = '0;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst_req", 32'(memReadReq), 32'd0);
        chk("rst_valid", 32'(instructionValid), 32'd0);
        chk("rst_fault", 32'(fetchFault), 32'd0);
        chk("rst_addr", memReadAddr, 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;
        instructionReady = 1'b1;

        // 1: basic fetch, immediate grant, one-cycle memory latency
        wait_valid(20, n, ok);
        chk("t1_valid_seen", 32'(ok), 32'd1);
        chk("t1_latency", n, 32'd4);
        #1;
        chk("t1_instr", instruction, 32'h20080005);
        chk("t1_pc", instructionPC, 32'h00400000);
        chk("t1_count", 32'(count), 32'd1);
        p0 = pulses;
        tick();
        chk("t1_one_pulse", pulses - p0, 32'd1);
        chk("t1_count_drop", 32'(count), 32'd0);
        wait_req(20, ok);
        instructionReady = 1'b0;
        chk("t1_req_seen", 32'(ok), 32'd1);
        chk("t1_next_addr", memReadAddr, 32'h00400004);

        // 2: decode stalls five cycles
        wait_valid(20, n, ok);
        chk("t2_valid_seen", 32'(ok), 32'd1);
        repeat (5) begin
            tick();
            chk("t2_hold_valid", 32'(instructionValid), 32'd1);
            chk("t2_hold_count", 32'(count), 32'd0);
            chk("t2_hold_noreq", 32'(memReadReq), 32'd0);
        end
        gnt_delay = 3;
        r0 = req_cycles;
        p0 = pulses;
        instructionReady = 1'b1;
        tick();
        instructionReady = 1'b0;
        chk("t2_one_pulse", pulses - p0, 32'd1);

        // 3: grant delayed three cycles
        wait_valid(40, n, ok);
        chk("t3_valid_seen", 32'(ok), 32'd1);
        chk("t3_req_cycles", req_cycles - r0, 32'd4);
        chk("t3_pc", instructionPC, 32'h00400008);
        chk("t3_instr", instruction, 32'h5A1A0008);

        // 4: redirect while waiting for data
        gnt_delay = 0;
        lat = 3;
        p0 = pulses;
        instructionReady = 1'b1;
        tick();
        instructionReady = 1'b0;
        wait_req(20, ok);
        chk("t4_req_seen", 32'(ok), 32'd1);
        wait_req_drop(20, ok);
        chk("t4_in_wait", 32'(ok), 32'd1);
        p0 = pulses;
        redirect = 1'b1;
        newpc = 32'h00400100;
        tick();
        redirect = 1'b0;
        lat = 1;
        saw = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instructionValid) saw = 1;
            if (memReadReq && memReadAddr == 32'h00400100) found = 1;
            else tick();
        end
        chk("t4_refetch_addr", 32'(found), 32'd1);
        chk("t4_stale_dropped", 32'(saw), 32'd0);
        chk("t4_no_count", pulses - p0, 32'd0);
        wait_valid(20, n, ok);
        chk("t4_valid_seen", 32'(ok), 32'd1);
        chk("t4_pc", instructionPC, 32'h00400100);
        chk("t4_instr", instruction, 32'h5A1A0100);

        // 5: redirect in the same cycle decode accepts
        p0 = pulses;
        instructionReady = 1'b1;
        redirect = 1'b1;
        newpc = 32'h00400200;
        #1;
        chk("t5_count_blocked", 32'(count), 32'd0);
        tick();
        redirect = 1'b0;
        instructionReady = 1'b0;
        chk("t5_valid_drop", 32'(instructionValid), 32'd0);
        chk("t5_no_pulse", pulses - p0, 32'd0);
        wait_valid(20, n, ok);
        chk("t5_valid_seen", 32'(ok), 32'd1);
        chk("t5_pc", instructionPC, 32'h00400200);

        // 6: misaligned PC faults until redirected
        redirect = 1'b1;
        newpc = 32'h00400002;
        tick();
        redirect = 1'b0;
        req_seen = 0;
        repeat (8) begin
            tick();
            if (memReadReq) req_seen = 1;
        end
        chk("t6_fault", 32'(fetchFault), 32'd1);
        chk("t6_no_req", 32'(req_seen), 32'd0);
        redirect = 1'b1;
        newpc = 32'h00400000;
        tick();
        redirect = 1'b0;
        chk("t6_fault_clear", 32'(fetchFault), 32'd0);
        wait_valid(20, n, ok);
        chk("t6_valid_seen", 32'(ok), 32'd1);
        chk("t6_instr", instruction, 32'h20080005);
        chk("t6_pc", instructionPC, 32'h00400000);

        // Asynchronous reset in the middle of a memory wait
        lat = 4;
        instructionReady = 1'b1;
        tick();
        instructionReady = 1'b0;
        wait_req(20, ok);
        chk("t6_req_seen", 32'(ok), 32'd1);
        wait_req_drop(20, ok);
        chk("t6_in_wait", 32'(ok), 32'd1);
        #3;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(memReadReq), 32'd0);
        chk("arst_addr", memReadAddr, 32'd0);
        chk("arst_valid", 32'(instructionValid), 32'd0);
        chk("arst_instr", instruction, 32'd0);
        chk("arst_pc", instructionPC, 32'd0);
        chk("arst_fault", 32'(fetchFault), 32'd0);
        chk("arst_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
